// File: rtl/note_fragment_recorder_if.sv
// Bundle between the note capture front end, the recorder and the Markov learner.
// master drives note events and the ready; slave (the recorder) drives the fragment side.
interface note_fragment_recorder_if #(
  parameter int SONG_INPUT_LEN = 16,
  parameter int NOTE_BIT_LEN   = 4,
  parameter int DELAY_BIT_LEN  = 8
);
  localparam int W  = NOTE_BIT_LEN + DELAY_BIT_LEN;
  localparam int CW = $clog2(SONG_INPUT_LEN + 1);

  logic                        start;
  logic                        stop;
  logic                        note_valid;
  logic [NOTE_BIT_LEN-1:0]     note_in;
  logic [SONG_INPUT_LEN*W-1:0] fragment;
  logic                        fragment_valid;
  logic                        fragment_ready;
  logic [CW-1:0]               count;
  logic                        recording;
  logic                        overrun;

  modport master (
    output start, stop, note_valid, note_in, fragment_ready,
    input  fragment, fragment_valid, count, recording, overrun
  );

  modport slave (
    input  start, stop, note_valid, note_in, fragment_ready,
    output fragment, fragment_valid, count, recording, overrun
  );
endinterface

// File: rtl/note_fragment_recorder.sv
// Records live notes with inter-note delays (prescaled, saturating) into a fixed-length
// fragment and hands the frozen fragment to the learner over valid/ready.

// One fragment slot: cleared at fragment start, written once when its note is captured.
module nfr_entry #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)        q_d = '0;
    else if (wr_en) q_d = wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

module note_fragment_recorder #(
  parameter int SONG_INPUT_LEN = 16,
  parameter int NOTE_BIT_LEN   = 4,
  parameter int DELAY_BIT_LEN  = 8,
  parameter int TICK_DIV       = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  note_fragment_recorder_if.slave bus
);
  localparam int W  = NOTE_BIT_LEN + DELAY_BIT_LEN;
  localparam int CW = $clog2(SONG_INPUT_LEN + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]            PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]            LAST_IDX  = CW'(SONG_INPUT_LEN - 1);
  localparam logic [DELAY_BIT_LEN-1:0] DELAY_MAX = '1;

  typedef enum logic [1:0] {IDLE, RECORD, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [DELAY_BIT_LEN-1:0] delay_q, delay_d;
  logic                     overrun_q, overrun_d;
  logic                     recording_q, recording_d;
  logic                     fvalid_q, fvalid_d;

  logic                     clr;
  logic                     cap;
  logic [DELAY_BIT_LEN-1:0] delay_field;
  logic [W-1:0]             wr_data;
  logic [SONG_INPUT_LEN-1:0][W-1:0] frag_w;

  // The first note of a fragment has no predecessor, so its delay is forced to 0.
  assign delay_field = (count_q == '0) ? '0 : delay_q;
  assign wr_data     = {bus.note_in, delay_field};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    delay_d   = delay_q;
    overrun_d = overrun_q;
    clr       = 1'b0;
    cap       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RECORD;
          count_d   = '0;
          presc_d   = '0;
          delay_d   = '0;
          overrun_d = 1'b0;
          clr       = 1'b1;
        end
      end
      RECORD: begin
        if (bus.note_valid) begin
          cap     = 1'b1;
          count_d = count_q + 1'b1;
          presc_d = '0;
          delay_d = '0;
          // A same-edge stop follows the capture, so count is nonzero here.
          if (count_q == LAST_IDX || bus.stop) state_d = HOLD;
        end else begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (delay_q != DELAY_MAX) delay_d = delay_q + 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (bus.stop) state_d = (count_q == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (bus.note_valid)     overrun_d = 1'b1;
        if (bus.fragment_ready) state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    recording_d = (state_d == RECORD);
    fvalid_d    = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      presc_q     <= '0;
      delay_q     <= '0;
      overrun_q   <= 1'b0;
      recording_q <= 1'b0;
      fvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      delay_q     <= delay_d;
      overrun_q   <= overrun_d;
      recording_q <= recording_d;
      fvalid_q    <= fvalid_d;
    end
  end

  for (genvar k = 0; k < SONG_INPUT_LEN; k++) begin : g_entry
    nfr_entry #(.W(W)) u_entry (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .wr_en   (cap && (count_q == CW'(k))),
      .wr_data (wr_data),
      .q       (frag_w[k])
    );
  end

  assign bus.fragment       = frag_w;
  assign bus.fragment_valid = fvalid_q;
  assign bus.count          = count_q;
  assign bus.recording      = recording_q;
  assign bus.overrun        = overrun_q;
endmodule
